// File: rtl/alu_issue_unit_if.sv
// Instruction, ALU and writeback signal bundle for alu_issue_unit.
// The slave modport is the issue unit's view; master is the surrounding pipeline/ALU view.
interface alu_issue_unit_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_source1;
  logic [31:0] alu_source2;
  logic [5:0]  alu_operation;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic        wb_zero;
  logic        wb_carry;
  logic [4:0]  wb_dest;
  logic        wb_illegal;

  modport slave (
    input  instr_valid, instr, rs_data, rt_data, alu_result, alu_zero, alu_carry, wb_ready,
    output instr_ready, alu_source1, alu_source2, alu_operation, alu_shamt,
           wb_valid, wb_result, wb_zero, wb_carry, wb_dest, wb_illegal
  );

  modport master (
    output instr_valid, instr, rs_data, rt_data, alu_result, alu_zero, alu_carry, wb_ready,
    input  instr_ready, alu_source1, alu_source2, alu_operation, alu_shamt,
           wb_valid, wb_result, wb_zero, wb_carry, wb_dest, wb_illegal
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Execute-stage sequencer: decodes MIPS op/funct into ALU codes, drives the ALU,
// captures its result and hands a packet to writeback; counts retired packets.
module alu_issue_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_unit_if.slave  bus,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_r, state_nx_s;
  logic        instr_ready_s, accept_s, retire_s;
  logic        dec_legal_s;
  logic [5:0]  dec_op_s;
  logic [31:0] dec_src1_s, dec_src2_s;
  logic [4:0]  dec_shamt_s, dec_dest_s;

  logic [31:0] alu_source1_r, alu_source2_r, wb_result_r;
  logic [5:0]  alu_operation_r;
  logic [4:0]  alu_shamt_r, dest_pend_r, wb_dest_r;
  logic        wb_valid_r, wb_zero_r, wb_carry_r, wb_illegal_r;
  logic [CNT_W-1:0] done_count_r;

  // Instruction decode into ALU operation and operand selection
  always_comb begin
    dec_legal_s = 1'b1;
    dec_op_s    = 6'd0;
    dec_src1_s  = bus.rs_data;
    dec_src2_s  = bus.rt_data;
    dec_shamt_s = bus.instr[10:6];
    dec_dest_s  = bus.instr[15:11];
    if (bus.instr[31:26] == 6'h00) begin
      case (bus.instr[5:0])
        6'h20, 6'h21: dec_op_s = 6'd27;
        6'h22, 6'h23: dec_op_s = 6'd28;
        6'h02: begin
          dec_op_s   = 6'd29;
          dec_src1_s = bus.rt_data;
          dec_src2_s = 32'd0;
        end
        6'h00: begin
          dec_op_s   = 6'd30;
          dec_src1_s = bus.rt_data;
          dec_src2_s = 32'd0;
        end
        6'h26:   dec_op_s = 6'd31;
        6'h24:   dec_op_s = 6'd32;
        default: dec_legal_s = 1'b0;
      endcase
    end else begin
      dec_shamt_s = 5'd0;
      dec_dest_s  = bus.instr[20:16];
      case (bus.instr[31:26])
        6'h08: begin
          dec_op_s   = 6'd27;
          dec_src2_s = {{16{bus.instr[15]}}, bus.instr[15:0]};
        end
        6'h0C: begin
          dec_op_s   = 6'd32;
          dec_src2_s = {16'd0, bus.instr[15:0]};
        end
        6'h0E: begin
          dec_op_s   = 6'd31;
          dec_src2_s = {16'd0, bus.instr[15:0]};
        end
        default: dec_legal_s = 1'b0;
      endcase
    end
  end

  // Next-state and instruction-ready logic; illegal instructions bypass EXEC
  always_comb begin
    instr_ready_s = 1'b0;
    state_nx_s    = state_r;
    case (state_r)
      IDLE: begin
        instr_ready_s = 1'b1;
        if (bus.instr_valid) begin
          state_nx_s = dec_legal_s ? EXEC : HOLD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: state_nx_s = HOLD;
      HOLD: begin
        instr_ready_s = bus.wb_ready;
        if (bus.wb_ready && bus.instr_valid) begin
          state_nx_s = dec_legal_s ? EXEC : HOLD;
        end else if (bus.wb_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  assign accept_s = bus.instr_valid & instr_ready_s;
  assign retire_s = (state_r == HOLD) & bus.wb_ready;

  // State, ALU drive, writeback packet and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      alu_source1_r   <= 32'd0;
      alu_source2_r   <= 32'd0;
      alu_operation_r <= 6'd0;
      alu_shamt_r     <= 5'd0;
      dest_pend_r     <= 5'd0;
      wb_valid_r      <= 1'b0;
      wb_result_r     <= 32'd0;
      wb_zero_r       <= 1'b0;
      wb_carry_r      <= 1'b0;
      wb_dest_r       <= 5'd0;
      wb_illegal_r    <= 1'b0;
      done_count_r    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (accept_s && dec_legal_s) begin
        alu_source1_r   <= dec_src1_s;
        alu_source2_r   <= dec_src2_s;
        alu_operation_r <= dec_op_s;
        alu_shamt_r     <= dec_shamt_s;
        dest_pend_r     <= dec_dest_s;
      end
      if (state_r == EXEC) begin
        wb_valid_r   <= 1'b1;
        wb_result_r  <= bus.alu_result;
        wb_zero_r    <= bus.alu_zero;
        wb_carry_r   <= bus.alu_carry;
        wb_dest_r    <= dest_pend_r;
        wb_illegal_r <= 1'b0;
      end else if (accept_s && !dec_legal_s) begin
        wb_valid_r   <= 1'b1;
        wb_result_r  <= 32'd0;
        wb_zero_r    <= 1'b0;
        wb_carry_r   <= 1'b0;
        wb_dest_r    <= 5'd0;
        wb_illegal_r <= 1'b1;
      end else if (retire_s) begin
        wb_valid_r <= 1'b0;
      end
      if (retire_s && (done_count_r != {CNT_W{1'b1}})) begin
        done_count_r <= done_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.instr_ready   = instr_ready_s;
  assign bus.alu_source1   = alu_source1_r;
  assign bus.alu_source2   = alu_source2_r;
  assign bus.alu_operation = alu_operation_r;
  assign bus.alu_shamt     = alu_shamt_r;
  assign bus.wb_valid      = wb_valid_r;
  assign bus.wb_result     = wb_result_r;
  assign bus.wb_zero       = wb_zero_r;
  assign bus.wb_carry      = wb_carry_r;
  assign bus.wb_dest       = wb_dest_r;
  assign bus.wb_illegal    = wb_illegal_r;
  assign done_count        = done_count_r;

endmodule
